qspi_slave_ram_if: RTL and testbench
====================================

Name: qspi_slave_ram_if

Overview:
- QSPI slave front end; the host MCU uses it to load input bytes into the shared frame RAM and to read result bytes back.
- Drives the same single-port byte RAM that the +5 adder stage uses.
- Write frames fill addresses 0x00-0x0F. Read frames fetch 0x10-0x1F.
- All QSPI pins are oversampled in the system clock domain; no sclk-clocked logic.

Parameters:
- addr_width, 8, RAM address width (1..8); the QSPI address byte is truncated to its low addr_width bits.
- SYNC_STAGES, 2, synchronizer depth on qspi_sclk, qspi_cs_n and qspi_io_in.

Ports:
- clk  input  1  system clock; qspi_sclk frequency must be <= clk/8.
- rst_n  input  1  asynchronous active-low reset.
- qspi_sclk  input  1  QSPI clock, mode 0 (idles low).
- qspi_cs_n  input  1  chip select, active low.
- qspi_io_in  input  4  IO[3:0] sampled value.
- qspi_io_out  output  4  IO[3:0] drive value.
- qspi_io_oe  output  1  IO output enable; the pad ring builds the tristate.
- addr  output  addr_width  RAM address.
- data_in  input  8  RAM read data; valid 1 clk after addr.
- data_out  output  8  RAM write data.
- wen  output  1  RAM write enable, 1-clk pulse per byte.
- busy  output  1  high while the frame is active (synced cs_n low).
- frame_done  output  1  1-clk pulse on synced cs_n rising edge.

Behaviour:
- Reset values: addr=0, data_out=0, wen=0, qspi_io_out=0, qspi_io_oe=0, busy=0, frame_done=0, FSM=IDLE, pointer=0.
- Edge detection:
  - sclk rise/fall are detected from the last two synchronized samples.
  - io is sampled from the synchronized copy on the rise event.
  - Drive updates on the fall event.
- Byte format: 4 bits per sclk; high nibble first.
- Frame format: CMD byte, ADDR byte, then payload.
- FSM states: IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE.
- IDLE: synced cs_n falling -> CMD; nibble counter cleared.
- CMD: after 2 rise events:
  - 0x02 -> ADDR (write).
  - 0x03 -> ADDR (read).
  - any other value -> IGNORE.
- ADDR: after 2 rise events, pointer = byte[addr_width-1:0].
  - Write -> WDATA.
  - Read -> DUMMY, with addr=pointer driven (prefetch).
- WDATA:
  - Every 2nd rise event completes a byte.
  - Next clk: addr=pointer, data_out=byte, wen=1 for exactly 1 clk.
  - Pointer then increments modulo 2^addr_width, so 0xFF wraps to 0x00 when addr_width=8.
- DUMMY: 2 rise events (one byte) of turnaround.
  - Prefetched data_in is latched into the tx shift register.
  - Pointer increments.
  - Next state RDATA.
- RDATA:
  - First fall event after DUMMY: qspi_io_oe=1 and qspi_io_out = tx[7:4].
  - Next fall event: qspi_io_out = tx[3:0].
  - On the rise event of the low nibble: addr=pointer, next byte latched 1 clk later, pointer increments.
  - sclk <= clk/8 guarantees the next byte is ready before the next fall.
  - Reads stream indefinitely with wrap.
- IGNORE: qspi_io_oe=0, no RAM access, held until cs_n high.
- cs_n high in any state:
  - FSM -> IDLE; qspi_io_oe=0 within 1 clk of the synced edge.
  - Partial byte is discarded: no wen.
  - frame_done pulses; busy=0.
  - A byte completed on the final rise still produces its wen. The wen has priority over the abort in the same clk.
- cs_n low glitch shorter than SYNC_STAGES clk: need not be detected.
- Async reset mid-frame: all outputs return to reset values immediately. The next frame starts only after cs_n has been seen high, then low.
- wen is never asserted while the FSM is in RDATA, DUMMY or IGNORE.

Decomposition:
- Shared package qspi_pkg holds:
  - CMD_WRITE=8'h02 and CMD_READ=8'h03.
  - The FSM state enum.
  - DUMMY_NIBBLES=2.
- One sub-module, qspi_sync_edge: SYNC_STAGES-deep synchronizer for sclk/cs_n/io, outputs sclk_rise, sclk_fall, cs_fall, cs_rise and the synced io.

Test Plan:
- Write 02,00 then bytes 00..0F at sclk=clk/8 -> 16 wen pulses, addr 0x00..0x0F, data_out = 0x00..0x0F; then one frame_done.
- RAM model preset 0x10..0x13 = 05,06,07,08; read 03,10, dummy, 4 bytes -> io_out nibbles 0,5,0,6,0,7,0,8, io_oe rises at the first post-dummy fall, no wen.
- Write 02,FF then AA,BB -> wen at addr 0xFF data 0xAA, then addr 0x00 data 0xBB (wrap).
- Unknown command 9F followed by 6 nibbles -> no wen, io_oe stays 0, frame_done at cs_n high.
- Write 02,20, one data nibble, then cs_n high -> no wen, FSM back to IDLE. A following write frame 02,21,5A -> wen addr 0x21 data 0x5A.
- rst_n low during RDATA with io_oe=1 -> io_oe=0 and addr=0 asynchronously. After release, a full read frame returns correct data.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared constants and FSM encoding for the QSPI slave RAM front end.
package qspi_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam int         DUMMY_NIBBLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/qspi_sync_edge.sv
// Synchronizes sclk/cs_n/io into the system clock and flags sclk/cs_n edges.
// Latency SYNC_STAGES clk to synced data, +0 clk to the edge strobes; no backpressure.
module qspi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic [3:0] i_io,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall,
  output logic       o_cs_fall,
  output logic       o_cs_rise,
  output logic [3:0] o_io
);

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic                        r_sclk_q;
  logic                        r_cs_q;
  logic                        w_sclk;
  logic                        w_cs_n;

  // cs_n resets to 0 so a frame already in progress at reset release is not
  // mistaken for a new one; cs_n must be seen high before a fall is reported.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_sclk_q <= 1'b0;
      r_cs_q   <= 1'b0;
    end else begin
      r_sync[0] <= {i_sclk, i_cs_n, i_io};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_sclk_q <= w_sclk;
      r_cs_q   <= w_cs_n;
    end
  end

  assign {w_sclk, w_cs_n, o_io} = r_sync[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_q;
  assign o_sclk_fall = ~w_sclk & r_sclk_q;
  assign o_cs_fall   = ~w_cs_n & r_cs_q;
  assign o_cs_rise   = w_cs_n & ~r_cs_q;

endmodule

// File: rtl/qspi_slave_ram_if.sv
// QSPI slave (quad, mode 0, oversampled) that writes/reads a single-port byte RAM.
// Write byte reaches RAM 1 clk after its 2nd nibble rise; host must keep sclk <= clk/8, no other backpressure.
module qspi_slave_ram_if
  import qspi_pkg::*;
#(
  parameter int addr_width  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_qspi_sclk,
  input  logic                  i_qspi_cs_n,
  input  logic [3:0]            i_qspi_io_in,
  output logic [3:0]            o_qspi_io_out,
  output logic                  o_qspi_io_oe,
  output logic [addr_width-1:0] o_addr,
  input  logic [7:0]            i_data_in,
  output logic [7:0]            o_data_out,
  output logic                  o_wen,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  logic            w_rise;
  logic            w_fall;
  logic            w_cs_fall;
  logic            w_cs_rise;
  logic [3:0]      w_io;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_nib;
  logic [3:0]      r_hi;
  logic            r_is_read;
  logic [addr_width-1:0] r_ptr;
  logic [7:0]      r_tx;
  logic [1:0]      r_fetch;
  logic            w_nib_last;
  logic            w_byte_done;
  logic [7:0]      w_byte;

  qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sclk      (i_qspi_sclk),
    .i_cs_n      (i_qspi_cs_n),
    .i_io        (i_qspi_io_in),
    .o_sclk_rise (w_rise),
    .o_sclk_fall (w_fall),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise),
    .o_io        (w_io)
  );

  assign w_nib_last  = (r_state == ST_DUMMY) ? (r_nib == 2'(DUMMY_NIBBLES - 1)) : (r_nib == 2'd1);
  assign w_byte_done = w_rise & w_nib_last;
  assign w_byte      = {r_hi, w_io};
  assign o_busy      = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_cs_fall) w_next = ST_CMD;
        ST_CMD:   if (w_byte_done) w_next = (w_byte == CMD_WRITE || w_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (w_byte_done) w_next = r_is_read ? ST_DUMMY : ST_WDATA;
        ST_DUMMY: if (w_byte_done) w_next = ST_RDATA;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr        <= '0;
      o_data_out    <= '0;
      o_wen         <= 1'b0;
      o_qspi_io_out <= '0;
      o_qspi_io_oe  <= 1'b0;
      o_frame_done  <= 1'b0;
      r_nib         <= '0;
      r_hi          <= '0;
      r_is_read     <= 1'b0;
      r_ptr         <= '0;
      r_tx          <= '0;
      r_fetch       <= '0;
    end else begin
      o_wen        <= 1'b0;
      o_frame_done <= w_cs_rise && (r_state != ST_IDLE);
      r_fetch      <= {r_fetch[0], 1'b0};
      // RAM data is valid one clk after addr, so the refill lands two clks after the request.
      if (r_fetch[1]) r_tx <= i_data_in;
      if (w_rise) begin
        r_nib <= w_nib_last ? 2'd0 : r_nib + 2'd1;
        r_hi  <= w_io;
      end
      case (r_state)
        ST_IDLE: if (w_cs_fall) r_nib <= '0;
        ST_CMD: if (w_byte_done) r_is_read <= (w_byte == CMD_READ);
        ST_ADDR: begin
          if (w_byte_done) begin
            r_ptr <= w_byte[addr_width-1:0];
            if (r_is_read) o_addr <= w_byte[addr_width-1:0];
          end
        end
        ST_WDATA: begin
          if (w_byte_done) begin
            o_wen      <= 1'b1;
            o_addr     <= r_ptr;
            o_data_out <= w_byte;
            r_ptr      <= r_ptr + 1'b1;
          end
        end
        ST_DUMMY: begin
          if (w_byte_done) begin
            r_tx  <= i_data_in;
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_RDATA: begin
          if (w_fall) begin
            o_qspi_io_oe  <= 1'b1;
            o_qspi_io_out <= (r_nib == 2'd0) ? r_tx[7:4] : r_tx[3:0];
          end
          if (w_byte_done) begin
            o_addr  <= r_ptr;
            r_ptr   <= r_ptr + 1'b1;
            r_fetch <= {r_fetch[0], 1'b1};
          end
        end
        default: ;
      endcase
      if (w_cs_rise) o_qspi_io_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_slave_ram_if.sv
// Randomized host-side bench: drives QSPI frames, models the RAM contents, checks writes and read nibbles.
module tb_qspi_slave_ram_if;
  import qspi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic       io_oe;
  logic [7:0] addr;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       wen;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wbuf [64];
  logic [7:0] wq_a [$];
  logic [7:0] wq_d [$];
  logic [3:0] rx_dat [$];
  logic       rx_oe [$];
  logic       dummy_oe [$];
  int         fd_cnt = 0;
  logic       oe_seen = 1'b0;
  logic [3:0] smp_dat;
  logic       smp_oe;

  always #5 clk = ~clk;

  qspi_slave_ram_if dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_qspi_sclk   (sclk),
    .i_qspi_cs_n   (cs_n),
    .i_qspi_io_in  (io_in),
    .o_qspi_io_out (io_out),
    .o_qspi_io_oe  (io_oe),
    .o_addr        (addr),
    .i_data_in     (data_in),
    .o_data_out    (data_out),
    .o_wen         (wen),
    .o_busy        (busy),
    .o_frame_done  (frame_done)
  );

  always @(posedge clk) begin
    if (wen) ram[addr] <= data_out;
    data_in <= ram[addr];
  end

  always @(negedge clk) begin
    if (wen) begin
      wq_a.push_back(addr);
      wq_d.push_back(data_out);
    end
    if (frame_done) fd_cnt++;
    if (io_oe) oe_seen = 1'b1;
  end

  task automatic clear_mon();
    wq_a.delete(); wq_d.delete(); rx_dat.delete(); rx_oe.delete(); dummy_oe.delete();
    fd_cnt = 0; oe_seen = 1'b0;
  endtask

  task automatic nib(input logic [3:0] v);
    @(negedge clk); io_in = v;
    repeat (4) @(negedge clk);
    smp_dat = io_out; smp_oe = io_oe;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    nib(b[7:4]); nib(b[3:0]);
  endtask

  task automatic cs_begin();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk); cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] a, input int n);
    cs_begin(); send(CMD_WRITE); send(a);
    for (int i = 0; i < n; i++) begin
      send(wbuf[i]);
      ref_mem[8'(a + i)] = wbuf[i];
    end
    cs_end();
  endtask

  task automatic host_read(input logic [7:0] a, input int n);
    cs_begin(); send(CMD_READ); send(a);
    for (int i = 0; i < DUMMY_NIBBLES; i++) begin
      nib(4'($urandom)); dummy_oe.push_back(smp_oe);
    end
    for (int i = 0; i < 2 * n; i++) begin
      nib(4'($urandom)); rx_dat.push_back(smp_dat); rx_oe.push_back(smp_oe);
    end
    cs_end();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h exp 00", addr); end
    n_cmp++; if (io_oe !== 1'b0 || io_out !== 4'h0) begin n_bad++; $display("FAIL reset_io got oe=%b out=%h exp 0/0", io_oe, io_out); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (data_out !== 8'h00 || wen !== 1'b0) begin n_bad++; $display("FAIL reset_wr got d=%h wen=%b exp 00/0", data_out, wen); end
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0 || fd_cnt != 0) begin n_bad++; $display("FAIL reset_status got busy=%b fd=%0d exp 0/0", busy, fd_cnt); end
  endtask

  task automatic test_write_seq();
    clear_mon();
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
    host_write(8'h00, 16);
    n_cmp++; if (wq_a.size() != 16) begin n_bad++; $display("FAIL wseq_count got %0d exp 16", wq_a.size()); end
    for (int i = 0; i < 16 && i < wq_a.size(); i++) begin
      n_cmp++; if (wq_a[i] !== 8'(i) || wq_d[i] !== 8'(i)) begin n_bad++; $display("FAIL wseq_byte%0d got a=%h d=%h exp a=%h d=%h", i, wq_a[i], wq_d[i], 8'(i), 8'(i)); end
    end
    n_cmp++; if (fd_cnt != 1) begin n_bad++; $display("FAIL wseq_frame_done got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_read();
    logic [7:0] pre [4];
    pre[0] = 8'h05; pre[1] = 8'h06; pre[2] = 8'h07; pre[3] = 8'h08;
    for (int i = 0; i < 4; i++) begin ram[8'h10 + i] = pre[i]; ref_mem[8'h10 + i] = pre[i]; end
    clear_mon();
    host_read(8'h10, 4);
    for (int i = 0; i < DUMMY_NIBBLES; i++) begin
      n_cmp++; if (dummy_oe[i] !== 1'b0) begin n_bad++; $display("FAIL read_dummy_oe%0d got %b exp 0", i, dummy_oe[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b; logic [3:0] e;
      b = ref_mem[8'h10 + i / 2];
      e = (i % 2 == 0) ? b[7:4] : b[3:0];
      n_cmp++; if (rx_dat[i] !== e || rx_oe[i] !== 1'b1) begin n_bad++; $display("FAIL read_nib%0d got %h oe=%b exp %h oe=1", i, rx_dat[i], rx_oe[i], e); end
    end
    n_cmp++; if (wq_a.size() != 0) begin n_bad++; $display("FAIL read_no_wen got %0d exp 0", wq_a.size()); end
    n_cmp++; if (io_oe !== 1'b0 || fd_cnt != 1) begin n_bad++; $display("FAIL read_end got oe=%b fd=%0d exp 0/1", io_oe, fd_cnt); end
  endtask

  task automatic test_wrap();
    clear_mon();
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    host_write(8'hFF, 2);
    n_cmp++; if (wq_a.size() != 2) begin n_bad++; $display("FAIL wrap_count got %0d exp 2", wq_a.size()); end
    if (wq_a.size() == 2) begin
      n_cmp++; if (wq_a[0] !== 8'hFF || wq_d[0] !== 8'hAA) begin n_bad++; $display("FAIL wrap_first got a=%h d=%h exp FF/AA", wq_a[0], wq_d[0]); end
      n_cmp++; if (wq_a[1] !== 8'h00 || wq_d[1] !== 8'hBB) begin n_bad++; $display("FAIL wrap_second got a=%h d=%h exp 00/BB", wq_a[1], wq_d[1]); end
    end
  endtask

  task automatic test_bad_cmd();
    clear_mon();
    cs_begin(); send(8'h9F);
    for (int i = 0; i < 6; i++) nib(4'($urandom));
    cs_end();
    n_cmp++; if (wq_a.size() != 0 || oe_seen !== 1'b0) begin n_bad++; $display("FAIL badcmd got wen=%0d oe_seen=%b exp 0/0", wq_a.size(), oe_seen); end
    n_cmp++; if (fd_cnt != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL badcmd_end got fd=%0d busy=%b exp 1/0", fd_cnt, busy); end
  endtask

  task automatic test_abort();
    clear_mon();
    cs_begin(); send(CMD_WRITE); send(8'h20); nib(4'h7); cs_end();
    n_cmp++; if (wq_a.size() != 0 || busy !== 1'b0 || fd_cnt != 1) begin n_bad++; $display("FAIL abort got wen=%0d busy=%b fd=%0d exp 0/0/1", wq_a.size(), busy, fd_cnt); end
    clear_mon();
    wbuf[0] = 8'h5A;
    host_write(8'h21, 1);
    n_cmp++; if (wq_a.size() != 1 || wq_a[0] !== 8'h21 || wq_d[0] !== 8'h5A) begin n_bad++; $display("FAIL abort_next got n=%0d a=%h d=%h exp 1/21/5A", wq_a.size(), wq_a.size() ? wq_a[0] : 8'h0, wq_d.size() ? wq_d[0] : 8'h0); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] a;
    a = 8'($urandom_range(1, 250));
    clear_mon();
    cs_begin(); send(CMD_READ); send(a);
    for (int i = 0; i < DUMMY_NIBBLES + 1; i++) nib(4'h0);
    n_cmp++; if (io_oe !== 1'b1) begin n_bad++; $display("FAIL rst_pre_oe got %b exp 1", io_oe); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++; if (io_oe !== 1'b0 || addr !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_async got oe=%b addr=%h busy=%b exp 0/00/0", io_oe, addr, busy); end
    repeat (3) @(negedge clk); rst_n = 1'b1;
    // cs_n still low from the interrupted frame: it must not start a new one
    send(CMD_WRITE); send(8'h30); send(8'h11);
    n_cmp++; if (wq_a.size() != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_stale_cs got wen=%0d busy=%b exp 0/0", wq_a.size(), busy); end
    cs_end();
    clear_mon();
    a = 8'($urandom);
    host_read(a, 3);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b; logic [3:0] e;
      b = ref_mem[8'(a + i / 2)];
      e = (i % 2 == 0) ? b[7:4] : b[3:0];
      n_cmp++; if (rx_dat[i] !== e) begin n_bad++; $display("FAIL rst_read_nib%0d got %h exp %h", i, rx_dat[i], e); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] a; int n;
      a = 8'($urandom); n = $urandom_range(1, 5);
      clear_mon();
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        host_write(a, n);
        n_cmp++; if (wq_a.size() != n) begin n_bad++; $display("FAIL rnd_wcount%0d got %0d exp %0d", it, wq_a.size(), n); end
        for (int i = 0; i < n && i < wq_a.size(); i++) begin
          n_cmp++; if (wq_a[i] !== 8'(a + i) || wq_d[i] !== wbuf[i]) begin n_bad++; $display("FAIL rnd_w%0d_%0d got a=%h d=%h exp a=%h d=%h", it, i, wq_a[i], wq_d[i], 8'(a + i), wbuf[i]); end
        end
      end else begin
        host_read(a, n);
        for (int i = 0; i < 2 * n; i++) begin
          logic [7:0] b; logic [3:0] e;
          b = ref_mem[8'(a + i / 2)];
          e = (i % 2 == 0) ? b[7:4] : b[3:0];
          n_cmp++; if (rx_dat[i] !== e || rx_oe[i] !== 1'b1) begin n_bad++; $display("FAIL rnd_r%0d_%0d got %h oe=%b exp %h oe=1", it, i, rx_dat[i], rx_oe[i], e); end
        end
        n_cmp++; if (wq_a.size() != 0) begin n_bad++; $display("FAIL rnd_r%0d_wen got %0d exp 0", it, wq_a.size()); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_write_seq();
    test_read();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
